// File: rtl/router_pkg.sv
// Shared packet-format definitions for the router encapsulator and decapsulator.
// Word layout: header in the top bits, destination below it, zeros beneath.
package router_pkg;

    localparam int unsigned AURORA_DATA_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH        = 10;
    localparam int unsigned NUMBER_PACKET     = 19;
    localparam int unsigned HEADER_WIDTH      = 9;

    localparam int unsigned TTL_WIDTH         = 2;
    localparam int unsigned PKT_NUM_WIDTH     = 5;
    localparam int unsigned SRC_ROUTER_WIDTH  = 2;

    localparam int unsigned HDR_LSB = AURORA_DATA_WIDTH - HEADER_WIDTH;
    localparam int unsigned DST_LSB = HDR_LSB - ADDR_WIDTH;

    localparam int unsigned SRC_ROUTER_LSB = 0;
    localparam int unsigned PKT_NUM_LSB    = SRC_ROUTER_WIDTH;
    localparam int unsigned TTL_LSB        = SRC_ROUTER_WIDTH + PKT_NUM_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_TRAILER,
        S_DONE
    } encap_state_e;

endpackage

// File: rtl/pkt_checksum_acc.sv
// Running XOR accumulator for the packet trailer.
// clr wins over en so a new packet always starts from zero.
module pkt_checksum_acc #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] acc
);

    // Accumulate each written word; cleared on reset or packet start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ d;
        end
    end

endmodule

// File: rtl/pkt_encapsulator.sv
// Builds header + payload + XOR trailer packets into the router input FIFO.
// Payload comes from a first-word-fall-through source; all strobes are combinational.
module pkt_encapsulator
    import router_pkg::*;
#(
    parameter int unsigned AURORA_DATA_WIDTH = router_pkg::AURORA_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH        = router_pkg::ADDR_WIDTH,
    parameter int unsigned NUMBER_PACKET     = router_pkg::NUMBER_PACKET,
    parameter int unsigned HEADER_WIDTH      = router_pkg::HEADER_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_encap_pkt,
    input  logic [ADDR_WIDTH-1:0]        router_dst_addr_send,
    input  logic [HEADER_WIDTH-1:0]      header_pkt_send,
    output logic                         encap_done,
    output logic                         encap_busy,
    input  logic                         src_empty,
    input  logic [AURORA_DATA_WIDTH-1:0] src_data,
    output logic                         src_rd,
    input  logic                         sink_full,
    output logic                         sink_wr,
    output logic [AURORA_DATA_WIDTH-1:0] sink_data
);

    localparam int unsigned CNT_W  = $clog2(NUMBER_PACKET);
    localparam int unsigned H_LSB  = AURORA_DATA_WIDTH - HEADER_WIDTH;
    localparam int unsigned D_LSB  = H_LSB - ADDR_WIDTH;

    encap_state_e state_q;
    encap_state_e state_d;

    logic [ADDR_WIDTH-1:0]        dst_q;
    logic [HEADER_WIDTH-1:0]      hdr_q;
    logic [CNT_W-1:0]             word_cnt;
    logic [AURORA_DATA_WIDTH-1:0] hdr_word;
    logic [AURORA_DATA_WIDTH-1:0] chk;
    logic                         accept;
    logic                         cnt_last;
    logic                         chk_en;

    assign accept   = (state_q == S_IDLE) && start_encap_pkt;
    assign cnt_last = (word_cnt == CNT_W'(NUMBER_PACKET - 3));
    assign chk_en   = sink_wr &&
                      ((state_q == S_HEADER) || (state_q == S_PAYLOAD));

    // Assemble the header word from the fields latched at start
    always_comb begin
        hdr_word = '0;
        hdr_word[H_LSB +: HEADER_WIDTH] = hdr_q;
        hdr_word[D_LSB +: ADDR_WIDTH]   = dst_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: each word phase advances only on an actual write
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start_encap_pkt)     state_d = S_HEADER;
            S_HEADER:  if (sink_wr)             state_d = S_PAYLOAD;
            S_PAYLOAD: if (sink_wr && cnt_last) state_d = S_TRAILER;
            S_TRAILER: if (sink_wr)             state_d = S_DONE;
            S_DONE:                             state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // Outputs: a stalled state drives no strobe but holds its data word
    always_comb begin
        sink_data  = '0;
        sink_wr    = 1'b0;
        src_rd     = 1'b0;
        encap_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
            end
            S_HEADER: begin
                sink_data = hdr_word;
                sink_wr   = !sink_full;
            end
            S_PAYLOAD: begin
                sink_data = src_data;
                src_rd    = !src_empty && !sink_full;
                sink_wr   = !src_empty && !sink_full;
            end
            S_TRAILER: begin
                sink_data = chk;
                sink_wr   = !sink_full;
            end
            S_DONE: begin
                encap_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign encap_busy = (state_q != S_IDLE);

    // Latch request fields on acceptance; count payload words written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dst_q    <= '0;
            hdr_q    <= '0;
            word_cnt <= '0;
        end else if (accept) begin
            dst_q    <= router_dst_addr_send;
            hdr_q    <= header_pkt_send;
            word_cnt <= '0;
        end else if ((state_q == S_PAYLOAD) && sink_wr) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    pkt_checksum_acc #(
        .W (AURORA_DATA_WIDTH)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (chk_en),
        .d     (sink_data),
        .acc   (chk)
    );

endmodule

// File: tb/tb_pkt_encapsulator.sv
// Directed bench for pkt_encapsulator with a FWFT source model
// and a scoreboard of expected sink words.
module tb_pkt_encapsulator;

    localparam int W  = 64;
    localparam int A  = 10;
    localparam int NP = 19;
    localparam int H  = 9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_encap_pkt;
    logic [A-1:0] router_dst_addr_send;
    logic [H-1:0] header_pkt_send;
    logic         encap_done;
    logic         encap_busy;
    logic         src_empty;
    logic [W-1:0] src_data;
    logic         src_rd;
    logic         sink_full;
    logic         sink_wr;
    logic [W-1:0] sink_data;

    always #5 clk = ~clk;

    pkt_encapsulator dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_encap_pkt      (start_encap_pkt),
        .router_dst_addr_send (router_dst_addr_send),
        .header_pkt_send      (header_pkt_send),
        .encap_done           (encap_done),
        .encap_busy           (encap_busy),
        .src_empty            (src_empty),
        .src_data             (src_data),
        .src_rd               (src_rd),
        .sink_full            (sink_full),
        .sink_wr              (sink_wr),
        .sink_data            (sink_data)
    );

    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_hdr;
    logic [W-1:0] last_trl;
    logic         starve;
    logic         pop_pending;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_wr = 0;
    int n_pop = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_edge = 0;
    int d0;

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        src_empty = starve || (src_q.size() == 0);
        src_data  = (src_q.size() != 0) ? src_q[0] : '0;
    endtask

    task automatic tick();
        logic [W-1:0] e;
        @(negedge clk);
        pop_pending = 1'b0;
        if (sink_wr === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("extra_write", W'(sink_wr), W'(0));
            end else begin
                e = exp_q.pop_front();
                check("sink_data", sink_data, e);
            end
        end
        if (src_rd === 1'b1) begin
            check("src_rd_without_wr", W'(sink_wr), W'(1));
            pop_pending = 1'b1;
        end
        if (sink_full === 1'b1) check("wr_while_full", W'(sink_wr), W'(0));
        if (starve) begin
            check("rd_while_starved", W'(src_rd), W'(0));
            check("wr_while_starved", W'(sink_wr), W'(0));
        end
        if (encap_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop_pending && src_q.size() != 0) begin
            void'(src_q.pop_front());
            n_pop++;
        end
        refresh();
    endtask

    task automatic load_pkt(input logic [H-1:0] h, input logic [A-1:0] d,
                            input logic [W-1:0] base, input logic [W-1:0] step);
        logic [W-1:0] c;
        logic [W-1:0] w;
        w = {h, d, {(W-H-A){1'b0}}};
        last_hdr = w;
        exp_q.push_back(w);
        c = w;
        for (int k = 1; k <= NP - 2; k++) begin
            w = base + step * W'(k);
            src_q.push_back(w);
            exp_q.push_back(w);
            c ^= w;
        end
        exp_q.push_back(c);
        last_trl = c;
        refresh();
    endtask

    task automatic start_pkt(input logic [H-1:0] h, input logic [A-1:0] d);
        header_pkt_send      = h;
        router_dst_addr_send = d;
        start_encap_pkt      = 1'b1;
        tick();
        start_encap_pkt      = 1'b0;
        start_edge           = cyc;
        n_wr                 = 0;
        n_pop                = 0;
    endtask

    task automatic wait_done(input int budget);
        int d;
        int i;
        d = done_cnt;
        i = 0;
        while (done_cnt == d && i < budget) begin
            tick();
            i++;
        end
        if (done_cnt == d) check("done_timeout", W'(done_cnt), W'(d + 1));
    endtask

    task automatic wait_pops(input int n, input int budget);
        int i;
        i = 0;
        while (n_pop < n && i < budget) begin
            tick();
            i++;
        end
        if (n_pop < n) check("pop_timeout", W'(n_pop), W'(n));
    endtask

    task automatic wait_wr(input int n, input int budget);
        int i;
        i = 0;
        while (n_wr < n && i < budget) begin
            tick();
            i++;
        end
        if (n_wr < n) check("wr_timeout", W'(n_wr), W'(n));
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_sink_wr"},   W'(sink_wr),    W'(0));
        check({tag, "_src_rd"},    W'(src_rd),     W'(0));
        check({tag, "_done"},      W'(encap_done), W'(0));
        check({tag, "_busy"},      W'(encap_busy), W'(0));
        check({tag, "_sink_data"}, sink_data,      W'(0));
    endtask

    initial begin
        rst_n                = 1'b0;
        start_encap_pkt      = 1'b0;
        router_dst_addr_send = '0;
        header_pkt_send      = '0;
        sink_full            = 1'b0;
        starve               = 1'b0;
        pop_pending          = 1'b0;
        refresh();
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Nominal packet
        load_pkt(9'b11_00011_00, 10'h2A5, 64'd0, 64'd1);
        start_pkt(9'b11_00011_00, 10'h2A5);
        check("nom_busy", W'(encap_busy), W'(1));
        wait_done(60);
        check("nom_latency", W'(done_cyc - start_edge + 1), W'(NP + 1));
        check("nom_writes", W'(n_wr), W'(NP));
        check("nom_sb_left", W'(exp_q.size()), W'(0));
        check("nom_idle_busy", W'(encap_busy), W'(0));
        check("nom_idle_data", sink_data, W'(0));

        // Source starvation
        load_pkt(9'b01_00100_10, 10'h155, 64'hC0DE_0000_0000_0000,
                 64'h0101_0101_0101_0101);
        start_pkt(9'b01_00100_10, 10'h155);
        wait_pops(4, 40);
        starve = 1'b1;
        refresh();
        repeat (5) tick();
        starve = 1'b0;
        refresh();
        wait_done(60);
        check("starve_latency", W'(done_cyc - start_edge + 1), W'(NP + 6));
        check("starve_writes", W'(n_wr), W'(NP));
        check("starve_sb_left", W'(exp_q.size()), W'(0));

        // Sink backpressure in HEADER and TRAILER
        load_pkt(9'b10_11111_01, 10'h3FF, 64'hFFFF_0000_FFFF_0000,
                 64'h1357_9BDF_2468_ACE0);
        start_pkt(9'b10_11111_01, 10'h3FF);
        sink_full = 1'b1;
        repeat (3) begin
            tick();
            check("hdr_hold", sink_data, last_hdr);
        end
        check("hdr_stall_wr", W'(n_wr), W'(0));
        sink_full = 1'b0;
        wait_wr(NP - 1, 60);
        sink_full = 1'b1;
        repeat (2) begin
            tick();
            check("trl_hold", sink_data, last_trl);
        end
        sink_full = 1'b0;
        wait_done(20);
        check("bp_writes", W'(n_wr), W'(NP));
        check("bp_latency", W'(done_cyc - start_edge + 1), W'(NP + 6));
        check("bp_sb_left", W'(exp_q.size()), W'(0));

        // Start while busy is ignored
        load_pkt(9'b11_00011_00, 10'h2A5, 64'hAAAA_5555_0000_1111,
                 64'h0000_0001_0000_0003);
        start_pkt(9'b11_00011_00, 10'h2A5);
        d0 = done_cnt;
        wait_pops(6, 40);
        header_pkt_send      = 9'b00_00001_11;
        router_dst_addr_send = 10'h001;
        start_encap_pkt      = 1'b1;
        tick();
        start_encap_pkt      = 1'b0;
        check("busy_hold", W'(encap_busy), W'(1));
        wait_done(60);
        repeat (25) tick();
        check("busy_one_done", W'(done_cnt - d0), W'(1));
        check("busy_writes", W'(n_wr), W'(NP));
        check("busy_sb_left", W'(exp_q.size()), W'(0));

        // Reset mid-packet, then a fresh full packet
        load_pkt(9'b01_01010_01, 10'h0F0, 64'h1234_5678_9ABC_DEF0,
                 64'h1111_1111_1111_1111);
        start_pkt(9'b01_01010_01, 10'h0F0);
        d0 = done_cnt;
        wait_pops(9, 40);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle_outputs("mid_rst");
        src_q.delete();
        exp_q.delete();
        refresh();
        repeat (3) tick();
        check("mid_rst_no_done", W'(done_cnt - d0), W'(0));
        load_pkt(9'b10_00101_10, 10'h2A5, 64'h0F0F_0F0F_0000_0000,
                 64'h0000_0000_0000_0007);
        start_pkt(9'b10_00101_10, 10'h2A5);
        wait_done(60);
        check("post_rst_writes", W'(n_wr), W'(NP));
        check("post_rst_latency", W'(done_cyc - start_edge + 1), W'(NP + 1));
        check("post_rst_sb_left", W'(exp_q.size()), W'(0));

        // Back-to-back: start in the done cycle is ignored
        load_pkt(9'b11_10000_00, 10'h011, 64'h0, 64'h0000_0100_0000_0001);
        start_pkt(9'b11_10000_00, 10'h011);
        wait_wr(NP, 60);
        check("b2b_done_now", W'(encap_done), W'(1));
        header_pkt_send      = 9'b01_00010_01;
        router_dst_addr_send = 10'h222;
        start_encap_pkt      = 1'b1;
        tick();
        check("b2b_ignored", W'(encap_busy), W'(0));
        load_pkt(9'b01_00010_01, 10'h222, 64'h5A5A_0000_0000_0000,
                 64'h0000_0000_0001_0001);
        tick();
        start_encap_pkt = 1'b0;
        start_edge      = cyc;
        n_wr            = 0;
        n_pop           = 0;
        check("b2b_accepted", W'(encap_busy), W'(1));
        tick();
        check("b2b_hdr_next", W'(n_wr), W'(1));
        wait_done(60);
        check("b2b_writes", W'(n_wr), W'(NP));
        check("b2b_sb_left", W'(exp_q.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pkt_encapsulator.md
# pkt_encapsulator

Builds one fixed-length packet per request and writes it into the input-port-0 FIFO of the router. It consumes the controller's `start_encap_pkt`, `router_dst_addr_send` and `header_pkt_send`, and returns `encap_done`. Payload words come from a first-word-fall-through local source FIFO. Each packet is one header word, `NUMBER_PACKET-2` payload words, and one XOR-checksum trailer word.

## Interface
- `AURORA_DATA_WIDTH`, 64: word width of the source FIFO and the sink FIFO.
- `ADDR_WIDTH`, 10: width of the destination address.
- `NUMBER_PACKET`, 19: total words per packet, header and trailer included. Must be ≥ 3.
- `HEADER_WIDTH`, 9: width of the header field. `HEADER_WIDTH + ADDR_WIDTH` must be ≤ `AURORA_DATA_WIDTH`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start_encap_pkt` in 1: request pulse from the router controller.
- `router_dst_addr_send` in ADDR_WIDTH: destination address, sampled at start.
- `header_pkt_send` in HEADER_WIDTH: header `{TTL[1:0], pkt_number[4:0], src_router[1:0]}`, sampled at start.
- `encap_done` out 1: one-cycle pulse when the packet is complete.
- `encap_busy` out 1: high from start acceptance until `encap_done`.
- `src_empty` in 1: payload source FIFO empty.
- `src_data` in AURORA_DATA_WIDTH: payload word, valid whenever `!src_empty` (FWFT).
- `src_rd` out 1: pop the payload source.
- `sink_full` in 1: input-port-0 FIFO full.
- `sink_wr` out 1: write strobe into the input-port-0 FIFO.
- `sink_data` out AURORA_DATA_WIDTH: word being written.

## Operation
States:
- **IDLE**
  - If `start_encap_pkt`: latch the destination address and header, clear the checksum, clear `word_cnt`, go to HEADER.
  - Otherwise stay in IDLE.
- **HEADER**
  - `sink_data = {hdr, dst, zeros}`, with header in [63:55] and dst in [54:45] at default widths.
  - `sink_wr = !sink_full`.
  - On a write: `chk ^= word` and go to PAYLOAD.
- **PAYLOAD**
  - `sink_data = src_data`.
  - `sink_wr = src_rd = !src_empty && !sink_full`. The two strobes are identical and combinational.
  - On a write: `chk ^= src_data`, increment `word_cnt`. The write that brings the count to `NUMBER_PACKET-2` moves to TRAILER.
- **TRAILER**
  - `sink_data = chk`.
  - `sink_wr = !sink_full`.
  - On a write, go to DONE.
- **DONE**
  - `encap_done = 1` for exactly this cycle, then go to IDLE.

General rules:
- `encap_busy = (state != IDLE)`.
- `start_encap_pkt` is ignored while busy; it is neither queued nor allowed to corrupt the latched fields.
- `word_cnt` width is `$clog2(NUMBER_PACKET)`. It never wraps: its maximum value is `NUMBER_PACKET-2`.
- Checksum is a plain bitwise XOR over the header word and all payload words. The trailer itself is not included.

## Timing
Reset values, taken when `rst_n` is low on a rising edge:
- State goes to IDLE; `chk`, `word_cnt` and the latched fields are cleared.
- All outputs read 0: `sink_wr`, `src_rd`, `encap_done`, `encap_busy`, `sink_data`.

Reset mid-packet: the FSM returns to IDLE at once. The partial packet already in the sink is not retracted, and no `encap_done` is produced.

Latency, with no stalls:
- Start sampled at edge N.
- Header written at edge N+1, payload at N+2 … N+NUMBER_PACKET-1, trailer at N+NUMBER_PACKET.
- `encap_done` is high during the cycle after the trailer edge.
- Minimum request-to-done: `NUMBER_PACKET+1` cycles.

Stalls:
- `sink_full` stalls every state and holds `sink_data` stable.
- `src_empty` stalls PAYLOAD only.
- While stalled, no pop and no write occur.

Back-to-back operation: a start in the same cycle as `encap_done` is ignored. The earliest accepted start is the cycle after `encap_done`.

`sink_data` in IDLE and DONE is 0.

## Structure
- Shared package (`router_pkg`): `AURORA_DATA_WIDTH`, `ADDR_WIDTH`, `NUMBER_PACKET`, `HEADER_WIDTH`, the header sub-field widths (TTL 2, pkt_number 5, src_router 2), header-word bit offsets, and the FSM state enum. The package is shared with the decapsulator so both sides agree on the format.
- One sub-module is natural: `pkt_checksum_acc`, an XOR accumulator with `clr` and `en` inputs. Everything else stays in this module.

## Test plan
- **Nominal packet.** dst=10'h2A5, hdr=9'b11_00011_00, payload k=1..17, no stalls.
  - Expect 19 writes: `{hdr,dst,45'b0}`, then payload 1..17, then trailer = XOR of all 18 words.
  - `encap_done` at cycle 20.
- **Source starvation.** `src_empty` forced high for 5 cycles after payload word 4.
  - Expect no `sink_wr` and no `src_rd` during the gap.
  - Word order intact; done at cycle 25.
- **Sink backpressure.** `sink_full` high for 3 cycles during HEADER and 2 during TRAILER.
  - `sink_data` holds steady through each stall.
  - Exactly 19 writes total.
- **Start while busy.** Second `start_encap_pkt` at payload word 6 with dst=10'h001.
  - Ignored; the trailer and header still use dst=10'h2A5.
  - Only one `encap_done`.
- **Reset mid-packet.** `rst_n` low for 1 cycle at payload word 9.
  - Next cycle: all outputs 0, `encap_busy`=0.
  - A new start then produces a full, correct 19-word packet with the checksum restarted.
- **Back-to-back.** Start asserted in the `encap_done` cycle, then again one cycle later.
  - First is ignored; second is accepted.
  - Header written 1 cycle after acceptance.
